// File: rtl/serial_compare_pkg.sv
// Shared types for the serial compare scheduler: control FSM states and comparator states.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_shift = 2'd1,
        st_done  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        cmp_equal   = 2'd0,
        cmp_less    = 2'd1,
        cmp_greater = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/serial_compare_msb_fsm.sv
// MSB-first bit-serial magnitude comparator; the first differing bit decides and the
// verdict is held until reset.
module serial_compare_msb_fsm
    import serial_compare_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    cmp_state_t state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= cmp_equal;
        end else if (state_reg == cmp_equal && a != b) begin
            state_reg <= a ? cmp_greater : cmp_less;
        end
    end

    assign a_less_b    = (state_reg == cmp_less);
    assign a_eq_b      = (state_reg == cmp_equal);
    assign a_greater_b = (state_reg == cmp_greater);

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one serial comparator among N_REQ requesters.
// Optional macro SERIAL_COMPARE_EARLY_TERM_EN ends a comparison as soon as it is decided.
module serial_compare_scheduler
    import serial_compare_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_a_less_b,
    output logic                   res_a_eq_b,
    output logic                   res_a_greater_b
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sched_state_t     state_reg, state_next;
    logic [ID_W-1:0]  last_grant_reg;
    logic [ID_W-1:0]  res_id_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [WIDTH-1:0] sh_a_reg, sh_b_reg;

    logic [WIDTH-1:0] a_word [N_REQ];
    logic [WIDTH-1:0] b_word [N_REQ];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [N_REQ-1:0] grant_onehot;
    logic             last_bit, early_done;
    logic             cmp_rst, cmp_a, cmp_b;
    logic             cmp_lt, cmp_eq, cmp_gt;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_word[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_word[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts one past the last winner so every pending requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(last_grant_reg) + off) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_onehot = N_REQ'(1) << grant_idx;
        req_ready    = (state_reg == st_idle && !rst && grant_found) ? grant_onehot : '0;
    end

    assign last_bit = (bit_cnt_reg == CNT_W'(WIDTH - 1));

`ifdef SERIAL_COMPARE_EARLY_TERM_EN
    assign early_done = ~cmp_eq;
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            st_idle:  if (grant_found) state_next = st_shift;
            st_shift: if (last_bit || early_done) state_next = st_done;
            st_done:  state_next = st_idle;
            default:  state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= st_idle;
            last_grant_reg <= ID_W'(N_REQ - 1);
            res_id_reg     <= '0;
            bit_cnt_reg    <= '0;
            sh_a_reg       <= '0;
            sh_b_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                st_idle: begin
                    if (grant_found) begin
                        sh_a_reg       <= a_word[grant_idx];
                        sh_b_reg       <= b_word[grant_idx];
                        res_id_reg     <= grant_idx;
                        last_grant_reg <= grant_idx;
                        bit_cnt_reg    <= '0;
                    end
                end
                st_shift: begin
                    sh_a_reg    <= sh_a_reg << 1;
                    sh_b_reg    <= sh_b_reg << 1;
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Holding the comparator in reset while idle makes each comparison start from equal.
    assign cmp_rst = rst | (state_reg == st_idle);
    assign cmp_a   = (state_reg == st_shift) ? sh_a_reg[WIDTH-1] : 1'b0;
    assign cmp_b   = (state_reg == st_shift) ? sh_b_reg[WIDTH-1] : 1'b0;

    serial_compare_msb_fsm u_cmp (
        .clk         (clk),
        .rst         (cmp_rst),
        .a           (cmp_a),
        .b           (cmp_b),
        .a_less_b    (cmp_lt),
        .a_eq_b      (cmp_eq),
        .a_greater_b (cmp_gt)
    );

    assign res_valid       = (state_reg == st_done);
    assign res_id          = res_id_reg;
    assign res_a_less_b    = res_valid & cmp_lt;
    assign res_a_eq_b      = res_valid & cmp_eq;
    assign res_a_greater_b = res_valid & cmp_gt;

endmodule
